dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 2, number of ACCESS cycles per transaction; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  request pending on port 0 (CPU MEM stage) / port 1 (loader).
REQ-005 req0_write / req1_write  input  1  1 = store, 0 = load.
REQ-006 req0_addr / req1_addr  input  32  byte address.
REQ-007 req0_wdata / req1_wdata  input  32  store data.
REQ-008 req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-009 resp0_valid / resp1_valid  output  1  transaction complete, one-cycle pulse.
REQ-010 resp0_rdata / resp1_rdata  output  32  load data, valid with respN_valid.
REQ-011 mem_addr  output  32  address to data memory.
REQ-012 mem_din  output  32  write data to data memory.
REQ-013 mem_read / mem_write  output  1  data memory read / write strobes.
REQ-014 mem_dout  input  32  data memory read data (combinational from mem_addr while mem_read=1).

Function
REQ-015 FSM states IDLE, ACCESS, RESP; exactly one transaction in flight.
REQ-016 IDLE: if any reqN_valid, grant one port per arbitration policy; latch addr, wdata, write, grant id; pulse granted reqN_ready combinationally that cycle; next state ACCESS, counter = 0.
REQ-017 reqN_ready only asserted in IDLE, only for the granted port, never for both; requester holds valid/fields stable until ready.
REQ-018 ACCESS: mem_addr = latched addr, mem_din = latched wdata; counter increments each cycle; leaves for RESP when counter == MEM_LATENCY-1.
REQ-019 Load: mem_read = 1 every ACCESS cycle; mem_dout captured into response register on last ACCESS cycle.
REQ-020 Store: mem_write = 1 only on last ACCESS cycle (exactly one write edge); mem_read = 0 throughout.
REQ-021 RESP: granted respN_valid = 1 for one cycle; respN_rdata = captured data for loads, 0 for stores; next state IDLE.
REQ-022 Latency: accept at cycle T -> respN_valid at T+MEM_LATENCY+1; next accept earliest T+MEM_LATENCY+2.
REQ-023 Outside ACCESS: mem_read = mem_write = 0, mem_addr = mem_din = 0; non-granted respN_rdata = 0.
REQ-024 Address passed unchanged; word alignment is the memory's concern (addr >> 2).
REQ-025 Requests arriving in ACCESS/RESP wait; no queueing beyond the requester's held valid.
REQ-026 Counter width 4 bits; MEM_LATENCY = 1 yields single ACCESS cycle with no wrap.

Reset
REQ-027 reset has priority over all state updates: state = IDLE, counter = 0, latched fields = 0, last_grant = 1.
REQ-028 All outputs 0 during and the cycle after reset.
REQ-029 Reset mid-ACCESS abandons the transaction: no mem_write issued, no respN_valid.

Configuration
REQ-030 Macro DMEM_ARB_ROUND_ROBIN_EN.
REQ-031 Defined: on simultaneous valid, grant the port not in last_grant; last_grant updated on every grant; first tie after reset goes to port 0.
REQ-032 Undefined: fixed priority, port 0 always wins ties; last_grant register absent.

Verification
REQ-033 Port 0 load addr 0x0000_0010, memory word 4 = 0xDEAD_BEEF, MEM_LATENCY=2 -> req0_ready at T, mem_read at T+1..T+2, resp0_valid with 0xDEAD_BEEF at T+3.
REQ-034 Port 1 store 0x1234_5678 to 0x20 -> single mem_write pulse at T+2, resp1_valid rdata 0 at T+3; subsequent port 0 load of 0x20 returns 0x1234_5678.
REQ-035 Both ports valid continuously, 4 transactions -> with DMEM_ARB_ROUND_ROBIN_EN grants 0,1,0,1; without it 0,0,0,0.
REQ-036 Store accepted, reset asserted at first ACCESS cycle -> no mem_write, no resp, all outputs 0 next cycle, target word unchanged.
REQ-037 MEM_LATENCY=1, back-to-back port 0 loads -> accepts at T and T+3, responses at T+2 and T+5.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port data-memory arbiter. Port 0 (CPU MEM stage) and port 1
//            (loader) share a single data memory. Exactly one transaction is
//            in flight: IDLE grants a port, ACCESS drives the memory for
//            MEM_LATENCY cycles, RESP returns a one-cycle response pulse.
// Ports    : clk, reset (sync, active-high)
//            reqN_valid/write/addr/wdata -> reqN_ready      (N = 0, 1)
//            respN_valid/respN_rdata                        (N = 0, 1)
//            mem_addr, mem_din, mem_read, mem_write -> memory; mem_dout <- memory
// Config   : DMEM_ARB_ROUND_ROBIN_EN defined   -> round-robin tie break
//            DMEM_ARB_ROUND_ROBIN_EN undefined -> port 0 fixed priority
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic [31:0] resp0_rdata,
    output logic        resp1_valid,
    output logic [31:0] resp1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);

    localparam logic [1:0] c_idle       = 2'd0;
    localparam logic [1:0] c_access     = 2'd1;
    localparam logic [1:0] c_resp       = 2'd2;
    localparam logic [3:0] c_last_count = 4'(MEM_LATENCY - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [3:0]  r_count;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_write;
    logic        r_grant;
    logic        r_rst_hold;
    logic        w_grant;
    logic        w_accept;
    logic        w_last;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Reset value 1 makes the first tie after reset go to port 0.
    logic r_last_grant;

    always_comb begin
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = ~req0_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
        end
    end
`else
    assign w_grant = ~req0_valid;
`endif

    // r_rst_hold blocks a grant in the cycle right after reset so every
    // output stays low for that cycle even if a requester is already valid.
    assign w_accept = (r_state == c_idle) && !reset && !r_rst_hold
                      && (req0_valid || req1_valid);
    assign w_last   = (r_state == c_access) && (r_count == c_last_count);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and outputs. All outputs are gated with reset so a reset
    // landing on the final ACCESS cycle cannot produce a write edge.
    always_comb begin
        w_state_next = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;
        resp0_rdata  = 32'd0;
        resp1_rdata  = 32'd0;
        mem_addr     = 32'd0;
        mem_din      = 32'd0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_accept) begin
                    w_state_next = c_access;
                    req0_ready   = ~w_grant;
                    req1_ready   = w_grant;
                end
            end
            c_access: begin
                if (w_last) begin
                    w_state_next = c_resp;
                end
                if (!reset) begin
                    mem_addr  = r_addr;
                    mem_din   = r_wdata;
                    mem_read  = ~r_write;
                    mem_write = r_write && w_last;
                end
            end
            c_resp: begin
                w_state_next = c_idle;
                if (!reset) begin
                    resp0_valid = ~r_grant;
                    resp1_valid = r_grant;
                    resp0_rdata = r_grant ? 32'd0 : r_rdata;
                    resp1_rdata = r_grant ? r_rdata : 32'd0;
                end
            end
            default: begin
                w_state_next = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= 4'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_write    <= 1'b0;
            r_grant    <= 1'b0;
            r_rdata    <= 32'd0;
            r_rst_hold <= 1'b1;
        end else begin
            r_rst_hold <= 1'b0;
            if (w_accept) begin
                r_count <= 4'd0;
                r_addr  <= w_grant ? req1_addr  : req0_addr;
                r_wdata <= w_grant ? req1_wdata : req0_wdata;
                r_write <= w_grant ? req1_write : req0_write;
                r_grant <= w_grant;
            end else if (r_state == c_access) begin
                r_count <= r_count + 4'd1;
                if (w_last) begin
                    // Stores answer with zero data.
                    r_rdata <= r_write ? 32'd0 : mem_dout;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter. Instance A uses
//            MEM_LATENCY=2, instance B uses MEM_LATENCY=1; each has its own
//            word-addressed memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A signals
    logic        a_req0_valid, a_req0_write, a_req0_ready;
    logic [31:0] a_req0_addr, a_req0_wdata;
    logic        a_req1_valid, a_req1_write, a_req1_ready;
    logic [31:0] a_req1_addr, a_req1_wdata;
    logic        a_resp0_valid, a_resp1_valid;
    logic [31:0] a_resp0_rdata, a_resp1_rdata;
    logic [31:0] a_mem_addr, a_mem_din, a_mem_dout;
    logic        a_mem_read, a_mem_write;

    // Instance B signals
    logic        b_req0_valid, b_req0_write, b_req0_ready;
    logic [31:0] b_req0_addr, b_req0_wdata;
    logic        b_req1_valid, b_req1_write, b_req1_ready;
    logic [31:0] b_req1_addr, b_req1_wdata;
    logic        b_resp0_valid, b_resp1_valid;
    logic [31:0] b_resp0_rdata, b_resp1_rdata;
    logic [31:0] b_mem_addr, b_mem_din, b_mem_dout;
    logic        b_mem_read, b_mem_write;

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic        bd_we, bd_sel;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;

    assign a_mem_dout = mem_a[a_mem_addr[7:2]];
    assign b_mem_dout = mem_b[b_mem_addr[7:2]];

    always @(posedge clk) begin
        if (a_mem_write) mem_a[a_mem_addr[7:2]] <= a_mem_din;
        if (b_mem_write) mem_b[b_mem_addr[7:2]] <= b_mem_din;
        if (bd_we && !bd_sel) mem_a[bd_idx] <= bd_data;
        if (bd_we &&  bd_sel) mem_b[bd_idx] <= bd_data;
    end

    dmem_arbiter #(.MEM_LATENCY(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .req0_valid(a_req0_valid), .req0_write(a_req0_write),
        .req0_addr(a_req0_addr), .req0_wdata(a_req0_wdata), .req0_ready(a_req0_ready),
        .req1_valid(a_req1_valid), .req1_write(a_req1_write),
        .req1_addr(a_req1_addr), .req1_wdata(a_req1_wdata), .req1_ready(a_req1_ready),
        .resp0_valid(a_resp0_valid), .resp0_rdata(a_resp0_rdata),
        .resp1_valid(a_resp1_valid), .resp1_rdata(a_resp1_rdata),
        .mem_addr(a_mem_addr), .mem_din(a_mem_din),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_dout(a_mem_dout)
    );

    dmem_arbiter #(.MEM_LATENCY(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .req0_valid(b_req0_valid), .req0_write(b_req0_write),
        .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_write(b_req1_write),
        .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata), .req1_ready(b_req1_ready),
        .resp0_valid(b_resp0_valid), .resp0_rdata(b_resp0_rdata),
        .resp1_valid(b_resp1_valid), .resp1_rdata(b_resp1_rdata),
        .mem_addr(b_mem_addr), .mem_din(b_mem_din),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_dout(b_mem_dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic bd_write(input logic sel, input logic [5:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        bd_we = 1'b1; bd_sel = sel; bd_idx = idx; bd_data = data;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // One transaction on instance A (MEM_LATENCY=2) with cycle-exact checks.
    task automatic a_txn(input int p, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input string tag);
        int waitc;
        logic rdy, oth;
        @(posedge clk); #1;
        if (p == 0) begin
            a_req0_valid = 1'b1; a_req0_write = wr; a_req0_addr = addr; a_req0_wdata = wdata;
        end else begin
            a_req1_valid = 1'b1; a_req1_write = wr; a_req1_addr = addr; a_req1_wdata = wdata;
        end
        #1;
        waitc = 0;
        rdy = (p == 0) ? a_req0_ready : a_req1_ready;
        while (!rdy && waitc < 20) begin
            @(posedge clk); #2;
            waitc++;
            rdy = (p == 0) ? a_req0_ready : a_req1_ready;
        end
        check({tag, "_ready"}, {31'd0, rdy}, 32'd1);
        oth = (p == 0) ? a_req1_ready : a_req0_ready;
        check({tag, "_other_ready"}, {31'd0, oth}, 32'd0);
        @(posedge clk); #1;
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check({tag, "_mem_read"},  {31'd0, a_mem_read},  {31'd0, !wr});
            check({tag, "_mem_write"}, {31'd0, a_mem_write}, {31'd0, wr && (i == 1)});
            check({tag, "_mem_addr"},  a_mem_addr, addr);
            if (wr) check({tag, "_mem_din"}, a_mem_din, wdata);
            check({tag, "_no_early_resp"}, {31'd0, a_resp0_valid | a_resp1_valid}, 32'd0);
            @(posedge clk); #1;
        end
        #1;
        check({tag, "_resp_valid"}, {30'd0, a_resp1_valid, a_resp0_valid}, (p == 0) ? 32'd1 : 32'd2);
        check({tag, "_resp_rdata"}, (p == 0) ? a_resp0_rdata : a_resp1_rdata, exp_rdata);
        check({tag, "_resp_other_rdata"}, (p == 0) ? a_resp1_rdata : a_resp0_rdata, 32'd0);
        check({tag, "_resp_mem_idle"}, {30'd0, a_mem_read, a_mem_write}, 32'd0);
    endtask

    int   grants [4];
    int   gcyc   [4];
    int   exp_g  [4];
    int   ng;
    int   acc_c [2];
    int   rsp_c [2];
    logic [31:0] rsp_d [2];
    int   na, nr;
    logic bad;

    initial begin
        reset = 1'b1;
        bd_we = 1'b0; bd_sel = 1'b0; bd_idx = 6'd0; bd_data = 32'd0;
        a_req0_valid = 1'b0; a_req0_write = 1'b0; a_req0_addr = 32'd0; a_req0_wdata = 32'd0;
        a_req1_valid = 1'b0; a_req1_write = 1'b0; a_req1_addr = 32'd0; a_req1_wdata = 32'd0;
        b_req0_valid = 1'b0; b_req0_write = 1'b0; b_req0_addr = 32'd0; b_req0_wdata = 32'd0;
        b_req1_valid = 1'b0; b_req1_write = 1'b0; b_req1_addr = 32'd0; b_req1_wdata = 32'd0;

        bd_write(1'b0, 6'd4, 32'hDEAD_BEEF);
        bd_write(1'b0, 6'd8, 32'h0000_0000);
        bd_write(1'b1, 6'd4, 32'hCAFE_F00D);
        bd_write(1'b1, 6'd5, 32'h0BAD_C0DE);

        // Outputs stay low during reset and the cycle after, even with a request pending.
        @(posedge clk); #1;
        a_req0_valid = 1'b1; a_req0_addr = 32'h10;
        #1;
        check("rst_ready0", {31'd0, a_req0_ready}, 32'd0);
        check("rst_mem", {30'd0, a_mem_read, a_mem_write}, 32'd0);
        check("rst_resp", {30'd0, a_resp0_valid, a_resp1_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_rst_ready0", {31'd0, a_req0_ready}, 32'd0);
        check("post_rst_mem_addr", a_mem_addr, 32'd0);

        // Load, store, load-back on instance A.
        a_txn(0, 1'b0, 32'h10, 32'd0,          32'hDEAD_BEEF, "load0");
        a_txn(1, 1'b1, 32'h20, 32'h1234_5678,  32'd0,         "store1");
        a_txn(0, 1'b0, 32'h20, 32'd0,          32'h1234_5678, "loadback0");
        check("mem_word8_after_store", mem_a[8], 32'h1234_5678);

        // Arbitration with both ports valid continuously.
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`else
        exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
`endif
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        a_req0_valid = 1'b1; a_req0_write = 1'b0; a_req0_addr = 32'h10;
        a_req1_valid = 1'b1; a_req1_write = 1'b0; a_req1_addr = 32'h30;
        ng = 0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin grants[i] = -1; gcyc[i] = -100; end
        for (int i = 0; i < 40 && ng < 4; i++) begin
            #1;
            if (a_req0_ready && a_req1_ready) bad = 1'b1;
            if (a_req0_ready || a_req1_ready) begin
                grants[ng] = a_req1_ready ? 1 : 0;
                gcyc[ng] = cyc;
                ng++;
            end
            @(posedge clk); #1;
        end
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;
        check("arb_both_ready", {31'd0, bad}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("arb_grant%0d", i), grants[i], exp_g[i]);
            if (i > 0) check($sformatf("arb_gap%0d", i), gcyc[i] - gcyc[i-1], 32'd4);
        end
        repeat (5) @(posedge clk);

        // Reset in the first ACCESS cycle of a store abandons it.
        @(posedge clk); #1;
        a_req1_valid = 1'b1; a_req1_write = 1'b1; a_req1_addr = 32'h20; a_req1_wdata = 32'hAAAA_AAAA;
        #1;
        check("abort_ready1", {31'd0, a_req1_ready}, 32'd1);
        @(posedge clk); #1;
        a_req1_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_rst_mem_write", {31'd0, a_mem_write}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_post_outputs",
              {a_mem_addr | a_mem_din | a_resp0_rdata | a_resp1_rdata},
              32'd0);
        check("abort_post_flags",
              {26'd0, a_mem_read, a_mem_write, a_resp0_valid, a_resp1_valid, a_req0_ready, a_req1_ready},
              32'd0);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            if (a_mem_write || a_resp1_valid || a_resp0_valid) bad = 1'b1;
        end
        check("abort_no_write_no_resp", {31'd0, bad}, 32'd0);
        check("abort_word_unchanged", mem_a[8], 32'h1234_5678);

        // MEM_LATENCY=1 back-to-back loads on instance B.
        @(posedge clk); #1;
        b_req0_valid = 1'b1; b_req0_write = 1'b0; b_req0_addr = 32'h10;
        na = 0; nr = 0;
        acc_c[0] = -100; acc_c[1] = -100; rsp_c[0] = -100; rsp_c[1] = -100;
        rsp_d[0] = 32'd0; rsp_d[1] = 32'd0;
        for (int i = 0; i < 20 && nr < 2; i++) begin
            #1;
            if (b_req0_ready && na < 2) begin acc_c[na] = cyc; na++; end
            if (b_resp0_valid && nr < 2) begin rsp_c[nr] = cyc; rsp_d[nr] = b_resp0_rdata; nr++; end
            @(posedge clk); #1;
            if (na == 1) b_req0_addr = 32'h14;
            if (na == 2) b_req0_valid = 1'b0;
        end
        b_req0_valid = 1'b0;
        check("lat1_accept_gap", acc_c[1] - acc_c[0], 32'd3);
        check("lat1_resp0_lat",  rsp_c[0] - acc_c[0], 32'd2);
        check("lat1_resp1_lat",  rsp_c[1] - acc_c[0], 32'd5);
        check("lat1_rdata0", rsp_d[0], 32'hCAFE_F00D);
        check("lat1_rdata1", rsp_d[1], 32'h0BAD_C0DE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
